riscv_regfile_sb: RTL and testbench
===================================

# riscv_regfile_sb

Parametrised multi-port integer register file for the RI5CY core, generalising the 3-read/2-write flip-flop file. It supports N read ports and N write ports, optional write-to-read bypass and a configurable hard-wired zero register. It also includes a per-register pending-write scoreboard that tracks destinations of long-latency operations (LSU, divider) until their writeback. It sits in the ID stage: reads feed operand muxes, writes come from EX/WB, and reservations come from the decoder.

## Interface
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- N_READ, 3, read ports (1..4)
- N_WRITE, 2, write ports (1..3); higher index has higher priority
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, is never busy
- BYPASS, 1, 1: same-cycle write data and busy-clear forwarded to read ports
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- test_en_i  in  1  DFT hint, no functional effect
- raddr_i  in  N_READ x ADDR_WIDTH  read addresses
- rdata_o  out  N_READ x DATA_WIDTH  read data, combinational
- rbusy_o  out  N_READ  busy bit of each read address, combinational
- waddr_i  in  N_WRITE x ADDR_WIDTH  write addresses
- wdata_i  in  N_WRITE x DATA_WIDTH  write data
- we_i  in  N_WRITE  write enables
- wclr_i  in  N_WRITE  write also clears busy bit of waddr (qualified by we_i)
- rsv_valid_i  in  1  reservation request
- rsv_addr_i  in  ADDR_WIDTH  register to mark busy
- rsv_ready_o  out  1  reservation accepted this cycle
- flush_i  in  1  clear all busy bits (pipeline kill)
- busy_o  out  NUM_WORDS  registered busy vector

## Operation
- Storage: NUM_WORDS x DATA_WIDTH flops. With ZERO_REG=1, word 0 is constant 0 and is not implemented as a flop.
- Write: on a rising edge, each word takes wdata of the highest-index port with we_i=1 and a matching waddr_i. Otherwise the word holds its value.
- Read: rdata_o[k] = word[raddr_i[k]]. With BYPASS=1 and a same-cycle write to that address (excluding r0 when ZERO_REG=1), rdata_o[k] = wdata of the highest-priority matching write port.
- Busy set: a handshake occurs when rsv_valid_i and rsv_ready_o are both high. It sets busy[rsv_addr_i] at the edge.
- rsv_ready_o = !busy[rsv_addr_i] || clear_hit, where clear_hit is a same-cycle we_i&wclr_i to rsv_addr_i, or flush_i. Reservations of r0 with ZERO_REG=1 are always ready and have no effect.
- Busy clear: any port with we_i&wclr_i clears busy[waddr] at the edge. flush_i clears all bits.
- Simultaneous events on one address: an accepted set wins over a clear or flush in the same cycle, because the new reservation supersedes the old one.
- rbusy_o[k] = busy[raddr_i[k]]. With BYPASS=1 it is forced low when a same-cycle clear targets that address and no set is accepted for it. It is 0 for r0 when ZERO_REG=1.
- Writes with wclr_i=0 to a busy register update data and leave busy unchanged. This supports forwarding of partial results.

## Timing
- Reset: all data words 0, busy_o all 0. rdata_o, rbusy_o and rsv_ready_o then follow combinationally: rdata_o=0, rbusy_o=0, rsv_ready_o=1.
- Read latency 0 cycles. Write visible through storage 1 cycle after the edge, or in the same cycle through the bypass.
- Busy set visible on busy_o and rbusy_o the cycle after acceptance. Clear visible the next cycle, or the same cycle through the bypass.
- rsv_ready_o depends combinationally on rsv_addr_i, we_i, wclr_i, waddr_i and flush_i. It does not depend on rsv_valid_i, so there is no loop.
- Reset asserted mid-operation clears data and busy immediately, regardless of pending reservations.

## Structure
- Package riscv_regfile_pkg holds the defaults REGFILE_ADDR_WIDTH=5, REGFILE_DATA_WIDTH=32, MAX_READ=4 and MAX_WRITE=3. It also holds a function returning the highest-priority matching write port index, shared by the write and bypass logic.
- One sub-module, riscv_regfile_scoreboard, holds the busy vector, the set/clear/flush arbitration, rsv_ready_o and the rbusy_o lookup.
- Data array, write decode and read/bypass muxes stay in the top module.

## Test plan
- Reset, then read all ports at addresses 0, 5 and 31 -> rdata_o=0, rbusy_o=0, busy_o=0, rsv_ready_o=1.
- Same cycle: port0 writes r7=0x1111_1111 and port1 writes r7=0x2222_2222, with raddr_i[0]=7 -> bypass shows 0x2222_2222 that cycle, and storage holds 0x2222_2222 afterwards. With BYPASS=0, the old value shows that cycle.
- Write r0=0xDEAD_BEEF and reserve r0 (ZERO_REG=1) -> r0 reads 0, rsv_ready_o=1, busy_o[0] stays 0.
- Reserve r3, then request r3 again the next cycle -> the second request sees rsv_ready_o=0. Then write r3=0x55 with wclr_i=1 -> rbusy_o drops the same cycle, rsv_ready_o=1, and busy_o[3]=0 the next cycle.
- In one cycle, reserve r9 accepted together with a port0 clear of r9 and flush_i=1 -> busy_o[9]=1 and all other bits 0 the next cycle.
- Reserve r12, then assert rst_n low asynchronously between edges -> busy_o and all data are 0 immediately, and r12 is not busy after release.

Source files
------------

// File: rtl/riscv_regfile_pkg.sv
// Shared defaults and write-port priority helper
// for the RI5CY multi-port register file.
package riscv_regfile_pkg;

  localparam int REGFILE_ADDR_WIDTH = 5;
  localparam int REGFILE_DATA_WIDTH = 32;
  localparam int MAX_READ           = 4;
  localparam int MAX_WRITE          = 3;
  localparam int WSEL_W             = $clog2(MAX_WRITE);

  function automatic logic [WSEL_W-1:0] wr_sel(
    input logic [MAX_WRITE-1:0] hit
  );
    logic [WSEL_W-1:0] sel;
    sel = '0;
    for (int p = 0; p < MAX_WRITE; p++)
      if (hit[p]) sel = WSEL_W'(p);
    return sel;
  endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Pending-write scoreboard: busy vector, set/clear
// arbitration, reservation ready and busy lookup.
module riscv_regfile_scoreboard
  import riscv_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int N_READ     = 3,
  parameter int N_WRITE    = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int NUM_WORDS = 2**ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_READ*ADDR_WIDTH-1:0] i_raddr,
  input  logic [N_WRITE*ADDR_WIDTH-1:0] i_waddr,
  input  logic [N_WRITE-1:0]           i_we,
  input  logic [N_WRITE-1:0]           i_wclr,
  input  logic                         i_rsv_valid,
  input  logic [ADDR_WIDTH-1:0]        i_rsv_addr,
  output logic                         o_rsv_ready,
  input  logic                         i_flush,
  output logic [N_READ-1:0]            o_rbusy,
  output logic [NUM_WORDS-1:0]         o_busy
);

  logic [NUM_WORDS-1:0] r_busy;
  logic [NUM_WORDS-1:0] w_clr;
  logic [NUM_WORDS-1:0] w_set;
  logic [NUM_WORDS-1:0] w_busy_nxt;
  logic                 w_rsv_zero;

  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] w_waddr;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]  w_raddr;

  assign w_waddr = i_waddr;
  assign w_raddr = i_raddr;

  assign w_rsv_zero = (ZERO_REG != 0) &&
                      (i_rsv_addr == '0);

  always_comb begin
    w_clr = {NUM_WORDS{i_flush}};
    for (int p = 0; p < N_WRITE; p++)
      if (i_we[p] && i_wclr[p])
        w_clr[w_waddr[p]] = 1'b1;
  end

  assign o_rsv_ready = w_rsv_zero ||
                       !r_busy[i_rsv_addr] ||
                       w_clr[i_rsv_addr];

  always_comb begin
    w_set = '0;
    if (i_rsv_valid && o_rsv_ready && !w_rsv_zero)
      w_set[i_rsv_addr] = 1'b1;
  end

  // a fresh reservation supersedes a clear or flush
  assign w_busy_nxt = w_set | (r_busy & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

  always_comb begin
    o_rbusy = '0;
    for (int k = 0; k < N_READ; k++) begin
      if (ZERO_REG != 0 && w_raddr[k] == '0)
        o_rbusy[k] = 1'b0;
      else if (BYPASS != 0)
        o_rbusy[k] = r_busy[w_raddr[k]] &
                     ~(w_clr[w_raddr[k]] &
                       ~w_set[w_raddr[k]]);
      else
        o_rbusy[k] = r_busy[w_raddr[k]];
    end
  end

endmodule

// File: rtl/riscv_regfile_sb.sv
// Parametrised N-read/N-write integer register file
// with write bypass and pending-write scoreboard.
module riscv_regfile_sb
  import riscv_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int N_READ     = 3,
  parameter int N_WRITE    = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int NUM_WORDS = 2**ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          test_en_i,
  input  logic [N_READ*ADDR_WIDTH-1:0]  raddr_i,
  output logic [N_READ*DATA_WIDTH-1:0]  rdata_o,
  output logic [N_READ-1:0]             rbusy_o,
  input  logic [N_WRITE*ADDR_WIDTH-1:0] waddr_i,
  input  logic [N_WRITE*DATA_WIDTH-1:0] wdata_i,
  input  logic [N_WRITE-1:0]            we_i,
  input  logic [N_WRITE-1:0]            wclr_i,
  input  logic                          rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]         rsv_addr_i,
  output logic                          rsv_ready_o,
  input  logic                          flush_i,
  output logic [NUM_WORDS-1:0]          busy_o
);

  logic w_unused_test_en;
  assign w_unused_test_en = test_en_i;

  logic [MAX_WRITE-1:0][ADDR_WIDTH-1:0] w_waddr;
  logic [MAX_WRITE-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [MAX_WRITE-1:0]                 w_we;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]    w_raddr;

  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    w_we    = '0;
    w_waddr[N_WRITE-1:0] = waddr_i;
    w_wdata[N_WRITE-1:0] = wdata_i;
    w_we[N_WRITE-1:0]    = we_i;
  end

  assign w_raddr = raddr_i;

  logic [NUM_WORDS-1:0][MAX_WRITE-1:0] w_whit;
  logic [DATA_WIDTH-1:0] w_word [NUM_WORDS];

  always_comb begin
    w_whit = '0;
    for (int w = 0; w < NUM_WORDS; w++)
      for (int p = 0; p < MAX_WRITE; p++)
        w_whit[w][p] = w_we[p] &&
          (w_waddr[p] == ADDR_WIDTH'(w));
  end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    if (ZERO_REG != 0 && w == 0) begin : g_zero
      assign w_word[w] = '0;
    end else begin : g_ff
      logic [DATA_WIDTH-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_q <= '0;
        else if (|w_whit[w])
          r_q <= w_wdata[wr_sel(w_whit[w])];
      end
      assign w_word[w] = r_q;
    end
  end

  logic [N_READ-1:0][MAX_WRITE-1:0] w_rhit;

  always_comb begin
    w_rhit  = '0;
    rdata_o = '0;
    for (int k = 0; k < N_READ; k++) begin
      for (int p = 0; p < MAX_WRITE; p++)
        w_rhit[k][p] = w_we[p] &&
          (w_waddr[p] == w_raddr[k]);
      if (ZERO_REG != 0 && w_raddr[k] == '0)
        w_rhit[k] = '0;
      if (BYPASS != 0 && |w_rhit[k])
        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
          w_wdata[wr_sel(w_rhit[k])];
      else
        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
          w_word[w_raddr[k]];
    end
  end

  riscv_regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_READ     (N_READ),
    .N_WRITE    (N_WRITE),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_raddr     (raddr_i),
    .i_waddr     (waddr_i),
    .i_we        (we_i),
    .i_wclr      (wclr_i),
    .i_rsv_valid (rsv_valid_i),
    .i_rsv_addr  (rsv_addr_i),
    .o_rsv_ready (rsv_ready_o),
    .i_flush     (flush_i),
    .o_rbusy     (rbusy_o),
    .o_busy      (busy_o)
  );

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Scoreboard-driven bench for riscv_regfile_sb,
// default config plus a BYPASS=0 twin.
module tb_riscv_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        test_en;
  logic [14:0] raddr;
  logic [95:0] rdata, rdata_nb;
  logic [2:0]  rbusy, rbusy_nb;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we, wclr;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready, rsv_ready_nb;
  logic        flush;
  logic [31:0] busy, busy_nb;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] mem [32];
  int n_vec, n_err;

  riscv_regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .wclr_i(wclr), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .flush_i(flush), .busy_o(busy)
  );

  riscv_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
    .raddr_i(raddr), .rdata_o(rdata_nb),
    .rbusy_o(rbusy_nb),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .wclr_i(wclr), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_nb),
    .flush_i(flush), .busy_o(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input int k);
    return rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rdn(input int k);
    return rdata_nb[k*32 +: 32];
  endfunction

  task automatic idle();
    we = '0; wclr = '0; waddr = '0; wdata = '0;
    rsv_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; test_en = 1'b0; idle();
    raddr = {5'd31, 5'd5, 5'd0}; rsv_addr = 5'd5;
    #12 rst_n = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rd(k) !== e) begin
        n_err++;
        $display("FAIL reset_rdata%0d got %h exp %h",
                 k, rd(k), e);
      end
    end
    e = exp_q.pop_front(); n_vec++;
    if ({29'd0, rbusy} !== e) begin
      n_err++;
      $display("FAIL reset_rbusy got %b exp %h", rbusy, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL reset_busy got %h exp %h", busy, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL reset_ready got %b exp %h",
               rsv_ready, e);
    end
  endtask

  task automatic test_bypass();
    cyc();
    we = 2'b11; waddr = {5'd7, 5'd7};
    wdata = {32'h2222_2222, 32'h1111_1111};
    raddr = {5'd0, 5'd0, 5'd7};
    exp_q.push_back(32'h2222_2222);
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL bypass_same got %h exp %h", rd(0), e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rdn(0) !== e) begin
      n_err++;
      $display("FAIL nobypass_old got %h exp %h",
               rdn(0), e);
    end
    cyc(); idle();
    exp_q.push_back(32'h2222_2222);
    exp_q.push_back(32'h2222_2222);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL bypass_store got %h exp %h", rd(0), e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rdn(0) !== e) begin
      n_err++;
      $display("FAIL nobypass_store got %h exp %h",
               rdn(0), e);
    end
  endtask

  task automatic test_zero();
    cyc();
    we = 2'b01; waddr = {5'd0, 5'd0};
    wdata = {32'h0, 32'hDEAD_BEEF};
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    raddr = {5'd0, 5'd0, 5'd0};
    exp_q.push_back(0); exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL zero_rd got %h exp %h", rd(0), e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL zero_ready got %b exp %h",
               rsv_ready, e);
    end
    cyc(); idle();
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL zero_busy got %h exp %h", busy, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL zero_store got %h exp %h", rd(0), e);
    end
  endtask

  task automatic test_reserve();
    cyc();
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    raddr = {5'd0, 5'd0, 5'd3};
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL rsv_first got %b exp %h",
               rsv_ready, e);
    end
    cyc();
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(32'h8);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL rsv_again got %b exp %h",
               rsv_ready, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rbusy[0]} !== e) begin
      n_err++;
      $display("FAIL rsv_rbusy got %b exp %h",
               rbusy[0], e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL rsv_busy got %h exp %h", busy, e);
    end
    cyc();
    rsv_valid = 1'b0;
    we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd3};
    wdata = {32'h0, 32'h55};
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(32'h55); exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rbusy[0]} !== e) begin
      n_err++;
      $display("FAIL clr_rbusy got %b exp %h",
               rbusy[0], e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL clr_ready got %b exp %h",
               rsv_ready, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL clr_rdata got %h exp %h", rd(0), e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rbusy_nb[0]} !== e) begin
      n_err++;
      $display("FAIL clr_rbusy_nb got %b exp %h",
               rbusy_nb[0], e);
    end
    cyc(); idle();
    exp_q.push_back(0); exp_q.push_back(32'h55);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL clr_busy got %h exp %h", busy, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL clr_store got %h exp %h", rd(0), e);
    end
  endtask

  task automatic test_set_wins();
    cyc();
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    cyc();
    rsv_addr = 5'd9; flush = 1'b1;
    we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd9};
    wdata = {32'h0, 32'h99};
    raddr = {5'd0, 5'd4, 5'd9};
    exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL win_ready got %b exp %h",
               rsv_ready, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rbusy[1]} !== e) begin
      n_err++;
      $display("FAIL flush_rbusy got %b exp %h",
               rbusy[1], e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rbusy_nb[1]} !== e) begin
      n_err++;
      $display("FAIL flush_rbusy_nb got %b exp %h",
               rbusy_nb[1], e);
    end
    cyc(); idle();
    exp_q.push_back(32'h200);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL win_busy got %h exp %h", busy, e);
    end
    cyc(); flush = 1'b1;
    cyc(); idle();
  endtask

  task automatic test_async_reset();
    cyc();
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    we = 2'b01; waddr = {5'd0, 5'd20};
    wdata = {32'h0, 32'hABCD};
    raddr = {5'd12, 5'd7, 5'd20};
    cyc(); idle();
    exp_q.push_back(32'h1000); exp_q.push_back(32'hABCD);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL pre_rst_busy got %h exp %h", busy, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL pre_rst_rd got %h exp %h", rd(0), e);
    end
    #1 rst_n = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL rst_busy got %h exp %h", busy, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rd(0) !== e) begin
      n_err++;
      $display("FAIL rst_r20 got %h exp %h", rd(0), e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (rd(1) !== e) begin
      n_err++;
      $display("FAIL rst_r7 got %h exp %h", rd(1), e);
    end
    #3 rst_n = 1'b1;
    cyc();
    exp_q.push_back(0); exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rbusy[2]} !== e) begin
      n_err++;
      $display("FAIL post_rst_rbusy got %b exp %h",
               rbusy[2], e);
    end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rsv_ready} !== e) begin
      n_err++;
      $display("FAIL post_rst_ready got %b exp %h",
               rsv_ready, e);
    end
  endtask

  task automatic test_random();
    logic [4:0]  a0, a2, wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  wev;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int it = 0; it < 60; it++) begin
      cyc();
      wev = 2'($urandom_range(0, 3));
      wa0 = 5'($urandom_range(0, 7));
      wa1 = 5'($urandom_range(0, 7));
      wd0 = $urandom; wd1 = $urandom;
      a0  = 5'($urandom_range(0, 7));
      a2  = 5'($urandom_range(0, 7));
      we = wev; waddr = {wa1, wa0};
      wdata = {wd1, wd0};
      raddr = {a2, 5'd0, a0};
      e = mem[a0];
      if (a0 != 0 && wev[0] && wa0 == a0) e = wd0;
      if (a0 != 0 && wev[1] && wa1 == a0) e = wd1;
      exp_q.push_back(e);
      exp_q.push_back(mem[a2]);
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (rd(0) !== e) begin
        n_err++;
        $display("FAIL rand_rd0 it%0d got %h exp %h",
                 it, rd(0), e);
      end
      e = exp_q.pop_front(); n_vec++;
      if (rdn(2) !== e) begin
        n_err++;
        $display("FAIL rand_nb_rd2 it%0d got %h exp %h",
                 it, rdn(2), e);
      end
      if (wev[0] && wa0 != 0) mem[wa0] = wd0;
      if (wev[1] && wa1 != 0) mem[wa1] = wd1;
    end
    cyc(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_bypass();
    test_zero();
    test_reserve();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
